button_leds: RTL and testbench

- Input-side counterpart to the board's LED drivers. Reads the two Alhambra-II push buttons SW1 and SW2 from the pads.
- Each button is synchronised and debounced, and a clean one-cycle press pulse is produced per press.
- An 8-bit up/down counter is kept and shown on LED0..LED7.
- Top-level leaf block. It also serves as the reusable front end for any later example that takes button input.

---
 rtl/button_leds_pkg.sv | 6 +
 rtl/button_leds_debounce.sv | 57 +++++
 rtl/button_leds.sv | 74 +++++++
 tb/tb_button_leds.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/button_leds_pkg.sv
// Shared constants for the button front end: board-default debounce time and
// the width of the LED counter.
package button_leds_pkg;
    localparam int DEBOUNCE_DEFAULT_12MHZ = 240000;
    localparam int COUNT_W                = 8;
endpackage

// File: rtl/button_leds_debounce.sv
// One button channel: two-flop synchroniser, hold-time debouncer and a
// registered one-cycle press pulse on each accepted rising level.
module button_leds_debounce
    import button_leds_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT_12MHZ
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw_in,
    output logic level,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q,      sync_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             level_q,     level_d;
    logic             level_dly_q, level_dly_d;
    logic             press_q,     press_d;

    always_comb begin
        sync_d      = {sync_q[0], raw_in};
        level_d     = level_q;
        cnt_d       = '0;
        level_dly_d = level_q;
        // Any cycle where sync agrees with level restarts the hold count.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
endmodule

// File: rtl/button_leds.sv
// Two debounced push buttons driving an 8-bit up/down counter shown on LED0..LED7.
// SW1 increments, SW2 decrements; simultaneous presses cancel.
module button_leds
    import button_leds_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT_12MHZ,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW1,
    input  logic SW2,
    output logic SW1_LEVEL,
    output logic SW2_LEVEL,
    output logic SW1_PRESS,
    output logic SW2_PRESS,
    output logic LED0,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic LED5,
    output logic LED6,
    output logic LED7
);
    logic               sw1_pressed, sw2_pressed;
    logic [COUNT_W-1:0] count_q, count_d;

    // Normalise to pressed=1 before the synchroniser so the debouncer is polarity-agnostic.
    assign sw1_pressed = SW1 ^ ACTIVE_LOW;
    assign sw2_pressed = SW2 ^ ACTIVE_LOW;

    button_leds_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
        .CLK    (CLK),
        .RST    (RST),
        .raw_in (sw1_pressed),
        .level  (SW1_LEVEL),
        .press  (SW1_PRESS)
    );

    button_leds_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw2 (
        .CLK    (CLK),
        .RST    (RST),
        .raw_in (sw2_pressed),
        .level  (SW2_LEVEL),
        .press  (SW2_PRESS)
    );

    always_comb begin
        count_d = count_q;
        case ({SW1_PRESS, SW2_PRESS})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign LED0 = count_q[0];
    assign LED1 = count_q[1];
    assign LED2 = count_q[2];
    assign LED3 = count_q[3];
    assign LED4 = count_q[4];
    assign LED5 = count_q[5];
    assign LED6 = count_q[6];
    assign LED7 = count_q[7];
endmodule

// File: tb/tb_button_leds.sv
// Directed, table-driven bench for button_leds with DEBOUNCE_CYCLES=4.
// Each table row: inputs applied, one clock edge, then all outputs compared.
module tb_button_leds;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw1 = 1'b0;
    logic sw2 = 1'b0;
    logic sw1_level, sw2_level, sw1_press, sw2_press;
    logic led0, led1, led2, led3, led4, led5, led6, led7;
    logic [7:0]  led;
    logic [11:0] obs;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    button_leds #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut (
        .CLK       (clk),
        .RST       (rst),
        .SW1       (sw1),
        .SW2       (sw2),
        .SW1_LEVEL (sw1_level),
        .SW2_LEVEL (sw2_level),
        .SW1_PRESS (sw1_press),
        .SW2_PRESS (sw2_press),
        .LED0      (led0),
        .LED1      (led1),
        .LED2      (led2),
        .LED3      (led3),
        .LED4      (led4),
        .LED5      (led5),
        .LED6      (led6),
        .LED7      (led7)
    );

    assign led = {led7, led6, led5, led4, led3, led2, led1, led0};
    assign obs = {sw1_level, sw2_level, sw1_press, sw2_press, led};

    typedef struct packed {
        logic       sw1;
        logic       sw2;
        logic       l1;
        logic       l2;
        logic       p1;
        logic       p2;
        logic [7:0] led;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s1, logic s2, logic l1, logic l2,
                                logic p1, logic p2, logic [7:0] ld);
        vec_t v;
        v.sw1 = s1; v.sw2 = s2; v.l1 = l1; v.l2 = l2;
        v.p1 = p1;  v.p2 = p2;  v.led = ld;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [11:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got lvl=%b%b prs=%b%b led=%02h, want lvl=%b%b prs=%b%b led=%02h",
                     name, idx, obs[11], obs[10], obs[9], obs[8], obs[7:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end else begin
            $display("ok   %s[%0d]: lvl=%b%b prs=%b%b led=%02h",
                     name, idx, obs[11], obs[10], obs[9], obs[8], obs[7:0]);
        end
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            sw1 = tbl[i].sw1;
            sw2 = tbl[i].sw2;
            step();
            check(name, i, {tbl[i].l1, tbl[i].l2, tbl[i].p1, tbl[i].p2, tbl[i].led});
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        sw1 = 1'b0;
        sw2 = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Hold a button 8 cycles then release 8 cycles; exactly one pulse expected.
    task automatic press(input logic s1, input logic s2, input string name);
        int pulses;
        pulses = 0;
        sw1 = s1;
        sw2 = s2;
        repeat (8) begin
            step();
            if ((s1 && sw1_press) || (s2 && sw2_press)) pulses++;
        end
        sw1 = 1'b0;
        sw2 = 1'b0;
        repeat (8) begin
            step();
            if ((s1 && sw1_press) || (s2 && sw2_press)) pulses++;
        end
        n_cmp++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL %s pulses: got %0d want 1", name, pulses);
        end
    endtask

    task automatic check_led(input string name, input logic [7:0] exp);
        n_cmp++;
        if (led !== exp) begin
            n_fail++;
            $display("FAIL %s: got led=%02h want %02h", name, led, exp);
        end else begin
            $display("ok   %s: led=%02h", name, led);
        end
    endtask

    initial begin
        logic [5:0] bounce;
        bounce = 6'b101101;  // applied LSB first: 1,0,1,1,0,1
        #1;
        do_reset();

        // Clean press of SW1, then release.
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk(1, 0, i >= 5, 0, i == 6, 0, (i >= 7) ? 8'h01 : 8'h00));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 0, i < 5, 0, 0, 0, 8'h01));
        run_table("clean");

        // Reset clears immediately, without a clock edge.
        rst = 1'b1;
        sw1 = 1'b1;
        sw2 = 1'b1;
        #1;
        check("async_rst", 0, 12'h000);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("in_rst", i, 12'h000);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(1, 0, i >= 5, 0, i == 6, 0, (i >= 7) ? 8'h01 : 8'h00));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 0, i < 5, 0, 0, 0, 8'h01));
        run_table("post_rst");

        // SW2 glitch of 3 cycles never reaches the level.
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(0, i < 3, 0, 0, 0, 0, 8'h01));
        run_table("glitch");

        // Bounce on SW1, then stable high.
        do_reset();
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk((i < 6) ? bounce[i] : 1'b1, 0, i >= 10, 0, i == 11, 0,
                             (i >= 12) ? 8'h01 : 8'h00));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 0, i < 5, 0, 0, 0, 8'h01));
        run_table("bounce");

        // Wrap in both directions.
        do_reset();
        press(0, 1, "wrap_dn");
        check_led("wrap_dn_led", 8'hFF);
        press(1, 0, "wrap_up");
        check_led("wrap_up_led", 8'h00);
        for (int i = 0; i < 255; i++) press(1, 0, "preset");
        check_led("preset_led", 8'hFF);
        press(1, 0, "wrap_ff");
        check_led("wrap_ff_led", 8'h00);

        // Simultaneous presses cancel.
        do_reset();
        for (int i = 0; i < 5; i++) press(1, 0, "to5");
        check_led("to5_led", 8'h05);
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(1, 1, i >= 5, i >= 5, i == 6, i == 6, 8'h05));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 0, i < 5, i < 5, 0, 0, 8'h05));
        run_table("both");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
